serial_add32_ctrl: RTL and testbench

SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

---
 rtl/add_pkg.sv | 13 +
 rtl/ripple_carry.sv | 21 ++
 rtl/serial_add32_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add32_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared defaults and FSM state type for the bit-serial (slice-serial) adder.
package add_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int SLICE_DEF  = 4;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index width for a slice counter; never zero even for a single slice.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ripple_carry.sv
// Slice adder: W-bit ripple-carry add with carry in/out.
module ripple_carry #(
  parameter int W = 4
) (
  output logic [W-1:0] s,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

// File: rtl/serial_add32_ctrl.sv
// Slice-serial add/subtract: one shared SLICE-bit adder walks the operands
// LSB slice first, one slice per cycle, then pulses done with s/cout/ovf.
module serial_add32_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = idx_w(NSLICE);
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_c;
  logic             sl_ovf;

  // Index mux on k selects the active slice; operands never shift.
  assign sl_a = a_r[k*SLICE +: SLICE];
  assign sl_b = b_r[k*SLICE +: SLICE];

  ripple_carry #(.W(SLICE)) u_slice (
    .s   (sl_s),
    .cout(sl_c),
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry)
  );

  // Signed overflow uses the top sum bit straight from the slice adder.
  assign sl_ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_s[SLICE-1] != a_r[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            k     <= '0;
            s     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          s[k*SLICE +: SLICE] <= sl_s;
          carry               <= sl_c;
          if (k == KLAST) begin
            cout  <= sl_c;
            ovf   <= sl_ovf;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Scoreboard bench: stimulus pushes expected {s,cout,ovf}; monitor pops on done.
module tb_serial_add32_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        busy, done, cout, ovf;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  serial_add32_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_busy_excl", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("result_s",    {32'd0, s},    {32'd0, e[33:2]});
        chk("result_cout", {63'd0, cout}, {63'd0, e[1]});
        chk("result_ovf",  {63'd0, ovf},  {63'd0, e[0]});
      end
    end
  end

  task automatic issue(input logic [31:0] ia, ib, input logic ic, isb,
                       input logic [31:0] es, input logic ec, eo, input bit expect_result);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = isb; start = 1'b1;
    if (expect_result) exp_q.push_back({es, ec, eo});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 20 cycles, expected done");
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] ia, ib, input logic ic, isb,
                        input logic [31:0] es, input logic ec, eo);
    int n;
    issue(ia, ib, ic, isb, es, ec, eo, 1'b1);
    wait_done(n);
    chk({name, "_latency"}, 64'(n), 64'd9);
  endtask

  initial begin
    int n, nbusy;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {29'd0, s, cout, ovf, busy, done}, 64'd0);

    run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_5m7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7m5",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op("add_cin",   32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Result holds in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_idle", {30'd0, s, cout, ovf}, {30'd0, 32'h7FFF_FFFF, 1'b1, 1'b1});

    // s clears on accept; mid-run start/operands are ignored; busy lasts 8 cycles.
    issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("s_cleared", {32'd0, s}, 64'd0);
    nbusy = 1;
    @(negedge clk); nbusy += int'(busy);
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk); nbusy += int'(busy);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin n = 1; break; end
      nbusy += int'(busy);
    end
    chk("ignore_done_seen", 64'(n), 64'd1);
    chk("busy_cycles", 64'(nbusy), 64'd8);

    // Reset mid-run: outputs clear, no done, then a normal operation.
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_run_outputs", {29'd0, s, cout, ovf, busy, done}, 64'd0);
    repeat (12) @(negedge clk);
    chk("rst_run_queue", 64'(exp_q.size()), 64'd0);
    run_op("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    // Back-to-back with start held through DONE.
    issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    wait_done(n);
    chk("b2b_first_latency", 64'(n), 64'd9);
    a = 32'h0000_0100; b = 32'h0000_0001; sub = 1'b1; cin = 1'b0;
    exp_q.push_back({32'h0000_00FF, 1'b1, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_no_idle", {63'd0, busy}, 64'd1);
    n = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    chk("b2b_done_spacing", 64'(n), 64'd9);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
